// File: rtl/bus_source_encoder.sv
// Registered bus-select encoder: turns one-hot drive strobes into the mux select code,
// with fixed-priority arbitration, conflict flagging/counting, freeze and a debug code.
//
// state  | meaning
// IDLE   | no source on the bus, select = 0
// DRIVE  | a source (or the debug code) owns the bus, reloaded every cycle
// FROZEN | select/grant held while bus_hold is high, requests ignored
module bus_source_encoder #(
  parameter int N_SRC      = 25,
  parameter int SEL_W      = 5,
  parameter int DEBUG_CODE = 31,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] drive_req,
  input  logic             debug_req,
  input  logic             bus_hold,
  output logic [SEL_W-1:0] select,
  output logic [N_SRC-1:0] grant,
  output logic             bus_valid,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_count
);

  if (N_SRC + 1 >= DEBUG_CODE) begin : g_bad_debug_code
    $error("bus_source_encoder: DEBUG_CODE must exceed N_SRC+1");
  end
  if ((1 << SEL_W) <= DEBUG_CODE) begin : g_bad_sel_w
    $error("bus_source_encoder: SEL_W too narrow for DEBUG_CODE");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, FROZEN} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_d;
  logic [N_SRC-1:0]   grant_d;
  logic               conflict_d;
  logic [CNT_W-1:0]   count_d;
  logic [N_SRC:0]     all_req;
  logic               any_req;
  logic               multi_req;

  assign all_req   = {drive_req, debug_req};
  assign any_req   = |all_req;
  // Clearing the lowest set bit leaves something only if two or more requests are up.
  assign multi_req = |(all_req & (all_req - (N_SRC+1)'(1)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      select         <= '0;
      grant          <= '0;
      bus_valid      <= 1'b0;
      conflict       <= 1'b0;
      conflict_count <= '0;
    end else begin
      state_q        <= state_d;
      select         <= sel_d;
      grant          <= grant_d;
      bus_valid      <= (sel_d != '0);
      conflict       <= conflict_d;
      conflict_count <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus_hold)
      state_d = FROZEN;
    else if (any_req)
      state_d = DRIVE;
    else
      state_d = IDLE;
  end

  always_comb begin
    sel_d      = select;
    grant_d    = grant;
    conflict_d = 1'b0;
    count_d    = conflict_count;
    if (!bus_hold) begin
      sel_d      = '0;
      grant_d    = '0;
      conflict_d = multi_req;
      if (debug_req) begin
        sel_d = SEL_W'(DEBUG_CODE);
      end else begin
        // Descending scan so the lowest set index is the last (winning) assignment.
        for (int k = N_SRC - 1; k >= 0; k--) begin
          if (drive_req[k]) begin
            sel_d   = SEL_W'(k + 1);
            grant_d = N_SRC'(1) << k;
          end
        end
      end
      if (multi_req && (conflict_count != '1))
        count_d = conflict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_source_encoder.sv
// Testbench for bus_source_encoder: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the selection rules.
module tb_bus_source_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] drive_req = '0;
  logic        debug_req = 1'b0;
  logic        bus_hold = 1'b0;
  logic [4:0]  select;
  logic [24:0] grant;
  logic        bus_valid;
  logic        conflict;
  logic [7:0]  conflict_count;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int unsigned m_sel   = 0;
  int unsigned m_grant = 0;
  int unsigned m_conf  = 0;
  int unsigned m_cnt   = 0;

  bus_source_encoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .drive_req      (drive_req),
    .debug_req      (debug_req),
    .bus_hold       (bus_hold),
    .select         (select),
    .grant          (grant),
    .bus_valid      (bus_valid),
    .conflict       (conflict),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [24:0] v);
    for (int i = 0; i < 25; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_update(input logic rn, input logic [24:0] rq, input logic dg, input logic hd);
    int n, w;
    if (!rn) begin
      m_sel = 0; m_grant = 0; m_conf = 0; m_cnt = 0;
    end else if (hd) begin
      m_conf = 0;
    end else begin
      n = $countones(rq) + (dg ? 1 : 0);
      m_conf = (n > 1) ? 1 : 0;
      w = lowest_set(rq);
      if (dg) begin
        m_sel = 31; m_grant = 0;
      end else if (w >= 0) begin
        m_sel = w + 1; m_grant = 1 << w;
      end else begin
        m_sel = 0; m_grant = 0;
      end
      if (m_conf == 1 && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic step(input logic rn, input logic [24:0] rq, input logic dg, input logic hd);
    reset_n   = rn;
    drive_req = rq;
    debug_req = dg;
    bus_hold  = hd;
    @(posedge clk);
    model_update(rn, rq, dg, hd);
    #1;
    chk("select",    32'(select),         m_sel);
    chk("grant",     32'(grant),          m_grant);
    chk("bus_valid", 32'(bus_valid),      (m_sel != 0) ? 1 : 0);
    chk("conflict",  32'(conflict),       m_conf);
    chk("count",     32'(conflict_count), m_cnt);
  endtask

  initial begin
    logic [24:0] r;
    #2;
    // reset holds outputs low even with a request present
    step(1'b0, 25'(1 << 4), 1'b0, 1'b0);
    chk("rst_sel", 32'(select), 0);
    chk("rst_valid", 32'(bus_valid), 0);
    step(1'b1, 25'(1 << 4), 1'b0, 1'b0);
    chk("rel_sel", 32'(select), 5);
    chk("rel_grant", 32'(grant), 32'h10);

    for (int k = 0; k < 25; k++) begin
      step(1'b1, 25'(1) << k, 1'b0, 1'b0);
      chk("sweep_sel", 32'(select), 32'(k + 1));
      chk("sweep_conf", 32'(conflict), 0);
    end

    step(1'b1, 25'h0000A00, 1'b0, 1'b0);
    chk("md_sel", 32'(select), 10);
    chk("md_grant", 32'(grant), 32'(1 << 9));
    chk("md_conf", 32'(conflict), 1);
    chk("md_cnt", 32'(conflict_count), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 25'h0000A00, 1'b0, 1'b0);
    chk("md_cnt4", 32'(conflict_count), 4);
    step(1'b1, 25'h0, 1'b0, 1'b0);
    chk("md_pulse_end", 32'(conflict), 0);

    step(1'b1, 25'h1, 1'b1, 1'b0);
    chk("dbg_sel", 32'(select), 31);
    chk("dbg_grant", 32'(grant), 0);
    chk("dbg_conf", 32'(conflict), 1);
    step(1'b1, 25'h0, 1'b1, 1'b0);
    chk("dbg_alone_conf", 32'(conflict), 0);

    step(1'b1, 25'(1 << 6), 1'b0, 1'b0);
    chk("frz_pre", 32'(select), 7);
    step(1'b1, 25'(1 << 2), 1'b0, 1'b1);
    step(1'b1, 25'h0C, 1'b0, 1'b1);
    step(1'b1, 25'h0C, 1'b0, 1'b1);
    chk("frz_sel", 32'(select), 7);
    chk("frz_conf", 32'(conflict), 0);
    chk("frz_cnt", 32'(conflict_count), 5);
    step(1'b1, 25'(1 << 2), 1'b0, 1'b0);
    chk("frz_rel", 32'(select), 3);

    for (int i = 0; i < 300; i++) step(1'b1, 25'h1000003, 1'b0, 1'b0);
    chk("sat_cnt", 32'(conflict_count), 255);
    step(1'b1, 25'h3, 1'b0, 1'b0);
    chk("sat_hold", 32'(conflict_count), 255);
    step(1'b1, 25'h3, 1'b0, 1'b1);
    step(1'b0, 25'h3, 1'b1, 1'b1);
    chk("rst_frz_cnt", 32'(conflict_count), 0);
    chk("rst_frz_sel", 32'(select), 0);
    chk("rst_frz_grant", 32'(grant), 0);

    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = 25'(1) << $urandom_range(0, 24);
        2: r = 25'($urandom);
        default: r = (25'(1) << $urandom_range(0, 24)) | (25'(1) << $urandom_range(0, 24));
      endcase
      step(($urandom_range(0, 99) != 0), r, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_source_encoder.md
Name: bus_source_encoder

Overview:
- Drive-side companion to the datapath bus multiplexer. Converts the per-source one-hot "drive" strobes from the control unit into the registered 5-bit select code that the mux consumes.
- Arbitrates illegal multi-driver requests by fixed priority and flags them. Supports bus freeze and a debug constant code.
- Sits between the control unit and the bus mux select input.

Parameters:
- N_SRC, 25, number of bus sources; data_k maps to select code k+1.
- SEL_W, 5, select code width.
- DEBUG_CODE, 31, code driven when a debug request wins; the mux outputs constant 3 for this code.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- drive_req  in  N_SRC  one-hot source drive strobes; bit k requests source data_k
- debug_req  in  1  request DEBUG_CODE on the bus
- bus_hold  in  1  freeze current select and grant
- select  out  SEL_W  registered select code to the bus mux (0 = idle)
- grant  out  N_SRC  registered one-hot grant, aligned with select
- bus_valid  out  1  high when select is nonzero
- conflict  out  1  one-cycle pulse when more than one request was presented
- conflict_count  out  CNT_W  saturating count of conflict events

Behaviour:
- Reset: reset_n low at a rising clk sets the following, regardless of other inputs:
  - select=0, grant=0, bus_valid=0, conflict=0, conflict_count=0
  - state=IDLE
- Latency: one cycle. Requests sampled at edge t appear on select and grant after edge t.
- Priority, evaluated each cycle:
  - debug_req beats any drive_req.
  - Otherwise, the lowest set index k of drive_req wins.
- Conflict: asserted when more than one of the following are high in the sampled cycle: debug_req, each bit of drive_req.
- Code map:
  - drive_req winner k gives select=k+1, grant=1<<k.
  - debug gives select=DEBUG_CODE, grant=0.
  - No request gives select=0, grant=0.
- bus_valid = (select != 0), registered together with select.
- FSM states: IDLE, DRIVE, FROZEN.
  - IDLE: no request gives IDLE. Any request gives DRIVE, with outputs loaded per priority.
  - DRIVE: select and grant reload every cycle from the current requests. No request returns to IDLE with select=0.
  - From IDLE or DRIVE, bus_hold=1 gives FROZEN. Outputs are held at their present values; requests in that cycle are ignored.
  - FROZEN: outputs held while bus_hold=1. When bus_hold drops, the next edge evaluates requests normally and goes to DRIVE or IDLE.
  - bus_hold has priority over requests. Reset has priority over everything.
- Conflict handling:
  - conflict is a registered single-cycle pulse per conflicting sample.
  - Back-to-back conflicting cycles give a pulse on each cycle.
  - Conflicts while FROZEN are not evaluated: no pulse, no count.
- conflict_count: increments by 1 per conflict pulse and saturates at 2^CNT_W-1 (no wrap). It is cleared only by reset.
- Codes 26..30 are never produced.
- Width rules:
  - Use index arithmetic at SEL_W bits.
  - N_SRC+1 must be less than DEBUG_CODE; check this at elaboration.
- Reset asserted mid-DRIVE or mid-FROZEN: the next edge clears all outputs; no residual grant.

Test Plan:
- Reset: hold reset_n=0 with drive_req=1<<4 -> select=0, grant=0, bus_valid=0. Release reset_n -> one edge later select=5, grant=0x10, bus_valid=1.
- Single-source sweep: drive_req=1<<k for k=0..24, one per cycle -> select=k+1 one cycle later; grant matches; conflict stays 0.
- Multi-driver: drive_req=0x0000_0A00 (bits 9, 11) -> select=10, grant=1<<9, conflict pulse for 1 cycle, conflict_count=1. Three more conflicting cycles -> count=4.
- Debug priority: debug_req=1 with drive_req=1<<0 -> select=31, grant=0, conflict=1. debug_req alone -> select=31, conflict=0.
- Freeze: in DRIVE with select=7, assert bus_hold for 3 cycles while changing drive_req to 1<<2 and 1<<3 (conflict) -> select stays 7, no conflict pulse. Drop bus_hold with drive_req=1<<2 -> select=3 next cycle.
- Saturation: force 300 conflicting cycles -> conflict_count stops at 255. Then reset_n=0 -> count=0, select=0.
